mac_accumulator: RTL

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_accumulator_pkg.sv | 24 ++
 rtl/mac_accumulator_lane.sv | 64 ++++++
 rtl/mac_accumulator.sv | 52 +++++
 3 files changed

// File: rtl/mac_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_accumulator_pkg
// Brief    : Shared constants and lane-vector type for the MAC accumulator
//            and the x/w block memories that feed it.
// Revision : 1.0 - initial release
// ============================================================================
package mac_accumulator_pkg;

    localparam int LANES  = 8;   // parallel dot-product lanes
    localparam int DATA_W = 32;  // operand / accumulator width
    localparam int CNT_W  = 6;   // element counter width (rows up to 64)

    // One DATA_W word per lane, packed so it can cross ports as a single bus
    typedef logic [LANES-1:0][DATA_W-1:0] lane_vec_t;

    // Negative sums collapse to zero when ReLU is requested
    function automatic logic [DATA_W-1:0] apply_relu(input logic [DATA_W-1:0] v,
                                                     input logic              en);
        return (en && v[DATA_W-1]) ? '0 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_accumulator_lane.sv
`default_nettype none
// ============================================================================
// Module   : mac_lane
// Brief    : One multiply-accumulate lane: wrapping 32-bit accumulator,
//            element counter, single-cycle emission with optional ReLU.
// Revision : 1.0 - initial release
// ============================================================================
module mac_lane
    import mac_accumulator_pkg::*;
(
    input  logic              clk,
    input  logic              reset,        // asynchronous, active low
    input  logic              enable,
    input  logic [CNT_W-1:0]  last_idx,     // N-1, compared live every edge
    input  logic              relu_en,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    input  logic              valid,
    input  logic              clear,
    output logic [DATA_W-1:0] chunk,
    output logic              chunk_valid
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] w_prod;
    logic [DATA_W-1:0] w_sum;
    logic              w_last;

    // Low word of the product is identical for signed and unsigned operands
    assign w_prod = x * w;
    // Element 0 starts a fresh sum, so stale accumulator contents never leak
    assign w_sum  = (r_cnt == '0) ? w_prod : (r_acc + w_prod);
    // Exact match only: a counter already past a shrunk N wraps through 63
    assign w_last = (r_cnt == last_idx);

    // Accumulate, count elements and emit the finished sum on the last one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            chunk       <= '0;
            chunk_valid <= 1'b0;
        end else if (enable) begin
            if (clear) begin
                r_cnt       <= '0;
                chunk_valid <= 1'b0;
            end else if (valid) begin
                r_acc       <= w_sum;
                r_cnt       <= w_last ? '0 : (r_cnt + c_cnt_one);
                chunk_valid <= w_last;
                if (w_last) begin
                    chunk <= apply_relu(w_sum, relu_en);
                end
            end else begin
                chunk_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mac_accumulator
// Brief    : Eight independent MAC lanes computing row dot products from the
//            x/w block-memory streams; row_done flags lane 7 emission.
// Revision : 1.0 - initial release
// ============================================================================
module mac_accumulator
    import mac_accumulator_pkg::*;
(
    input  logic             clk,
    input  logic             reset,        // asynchronous, active low
    input  logic             enable,
    input  logic [8:0]       size,
    input  logic             relu_en,
    input  lane_vec_t        x_in,
    input  lane_vec_t        w_in,
    input  logic [LANES-1:0] valid_in,
    input  logic [LANES-1:0] clear_in,
    output lane_vec_t        chunk_out,
    output logic [LANES-1:0] chunk_valid,
    output logic             row_done
);

    // Upper size bits carry no meaning for this block
    logic w_size_unused;
    assign w_size_unused = ^size[8:CNT_W];

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            mac_lane u_lane (
                .clk         (clk),
                .reset       (reset),
                .enable      (enable),
                .last_idx    (size[CNT_W-1:0]),
                .relu_en     (relu_en),
                .x           (x_in[i]),
                .w           (w_in[i]),
                .valid       (valid_in[i]),
                .clear       (clear_in[i]),
                .chunk       (chunk_out[i]),
                .chunk_valid (chunk_valid[i])
            );
        end
    endgenerate

    // Lane 7 is the last of the staggered chain, so its pulse marks the row;
    // deriving it directly keeps it coincident, frozen and reset with lane 7
    assign row_done = chunk_valid[LANES-1];

endmodule
`default_nettype wire
